// File: rtl/kernel_coeff_pingpong_pkg.sv
// Shared types and default geometry for the ping-pong kernel coefficient store.
package kernel_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_N_CH  = 32;
  localparam int DEFAULT_DEPTH = 18;

  typedef logic [DEFAULT_WIDTH-1:0] coeff_t;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } kload_state_e;

endpackage

// File: rtl/kernel_coeff_bank.sv
// One coefficient bank: DEPTH rows of N_CH coefficients, single-lane write port,
// combinational full-row read.
module kernel_coeff_bank
  import kernel_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N_CH  = DEFAULT_N_CH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [CW-1:0]         wr_ch,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [N_CH*WIDTH-1:0] rd_row
);

  logic [WIDTH-1:0] mem [DEPTH][N_CH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr][wr_ch] <= wr_data;
    end
  end

  // Out-of-range addresses are masked by the caller.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
      assign rd_row[gi*WIDTH +: WIDTH] = mem[rd_addr][gi];
    end
  endgenerate

endmodule

// File: rtl/kernel_coeff_pingpong.sv
// Double-buffered kernel coefficient store: loader fills the shadow bank while the PE
// array reads the active bank. Optional KERNEL_COEFF_CKSUM_EN adds a load checksum port.
module kernel_coeff_pingpong
  import kernel_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N_CH  = DEFAULT_N_CH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [WIDTH-1:0]      ld_data,
  input  logic                  ld_restart,
  output logic                  ld_done,
  input  logic                  swap_req,
  output logic                  bank_sel,
  output logic                  act_valid,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [N_CH*WIDTH-1:0] rd_data,
  output logic                  rd_valid
`ifdef KERNEL_COEFF_CKSUM_EN
  ,
  output logic [WIDTH+$clog2(N_CH*DEPTH)-1:0] cksum
`endif
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  kload_state_e state_reg, state_next;
  logic [CW-1:0] ch_cnt_reg;
  logic [AW-1:0] addr_cnt_reg;
  logic          accept;
  logic          swap_ok;
  logic          last_beat;
  logic          rd_in_range;
  logic [1:0]    bank_we;
  logic [N_CH*WIDTH-1:0] rows [2];

  assign last_beat   = (ch_cnt_reg == CW'(N_CH - 1)) && (addr_cnt_reg == AW'(DEPTH - 1));
  assign rd_in_range = ({1'b0, rd_addr} < (AW + 1)'(DEPTH));

  always_comb begin
    state_next = state_reg;
    ld_ready   = 1'b0;
    ld_done    = 1'b0;
    accept     = 1'b0;
    swap_ok    = 1'b0;
    case (state_reg)
      LOAD: begin
        ld_ready = rst_n;
        accept   = rst_n && ld_valid && !ld_restart;
        if (accept && last_beat) begin
          state_next = FULL;
        end
      end
      FULL: begin
        ld_done = 1'b1;
        if (swap_req && !ld_restart) begin
          swap_ok    = 1'b1;
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
    // Restart overrides everything, including a simultaneous swap.
    if (ld_restart) begin
      state_next = LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  // Channel is the inner loop, address the outer one.
  always_ff @(posedge clk) begin
    if (!rst_n || ld_restart) begin
      ch_cnt_reg   <= '0;
      addr_cnt_reg <= '0;
    end else if (accept) begin
      if (ch_cnt_reg == CW'(N_CH - 1)) begin
        ch_cnt_reg   <= '0;
        addr_cnt_reg <= last_beat ? '0 : addr_cnt_reg + 1'b1;
      end else begin
        ch_cnt_reg <= ch_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_sel  <= 1'b0;
      act_valid <= 1'b0;
    end else if (swap_ok) begin
      bank_sel  <= ~bank_sel;
      act_valid <= 1'b1;
    end
  end

  // The write bank is always the one not selected for reads.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      assign bank_we[gi] = accept && (bank_sel != 1'(gi));
      kernel_coeff_bank #(
        .WIDTH (WIDTH),
        .N_CH  (N_CH),
        .DEPTH (DEPTH)
      ) u_bank (
        .clk     (clk),
        .we      (bank_we[gi]),
        .wr_ch   (ch_cnt_reg),
        .wr_addr (addr_cnt_reg),
        .wr_data (ld_data),
        .rd_addr (rd_addr),
        .rd_row  (rows[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_in_range ? (bank_sel ? rows[1] : rows[0]) : '0;
      end
    end
  end

`ifdef KERNEL_COEFF_CKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n || ld_restart || swap_ok) begin
      cksum <= '0;
    end else if (accept) begin
      cksum <= cksum + ($bits(cksum))'(ld_data);
    end
  end
`endif

endmodule

// File: tb/tb_kernel_coeff_pingpong.sv
// Directed bench for kernel_coeff_pingpong; checks the cksum port when KERNEL_COEFF_CKSUM_EN is defined.
module tb_kernel_coeff_pingpong;

  localparam int WIDTH = 16;
  localparam int N_CH  = 32;
  localparam int DEPTH = 18;
  localparam int AW    = 5;
  localparam int NB    = N_CH * DEPTH;
  localparam int RW    = N_CH * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ld_valid;
  logic             ld_ready;
  logic [WIDTH-1:0] ld_data;
  logic             ld_restart;
  logic             ld_done;
  logic             swap_req;
  logic             bank_sel;
  logic             act_valid;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [RW-1:0]    rd_data;
  logic             rd_valid;
`ifdef KERNEL_COEFF_CKSUM_EN
  logic [WIDTH+$clog2(NB)-1:0] cksum;
`endif

  int passed = 0;
  int total  = 0;

  kernel_coeff_pingpong #(
    .WIDTH (WIDTH),
    .N_CH  (N_CH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_restart (ld_restart),
    .ld_done    (ld_done),
    .swap_req   (swap_req),
    .bank_sel   (bank_sel),
    .act_valid  (act_valid),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
`ifdef KERNEL_COEFF_CKSUM_EN
    ,
    .cksum      (cksum)
`endif
  );

  always #5 clk = ~clk;

  // Pattern 0: ch*256+addr, 1: 0xAAAA, 2: all ones (value 1), 3: 0x1000+ch*256+addr.
  function automatic logic [WIDTH-1:0] coeff(input int pat, input int c, input int a);
    case (pat)
      0:       return 16'(c * 256 + a);
      1:       return 16'hAAAA;
      2:       return 16'h0001;
      default: return 16'(16'h1000 + c * 256 + a);
    endcase
  endfunction

  function automatic logic [RW-1:0] row(input int pat, input int a);
    logic [RW-1:0] r;
    r = '0;
    for (int c = 0; c < N_CH; c++) r[c*WIDTH +: WIDTH] = coeff(pat, c, a);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic load(input int pat, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      if (i == NB - 1) begin
        check("pre_last_ld_done", RW'(ld_done), RW'(0));
        check("pre_last_ld_ready", RW'(ld_ready), RW'(1));
      end
      ld_valid = 1'b1;
      ld_data  = coeff(pat, i % N_CH, i / N_CH);
      tick();
    end
    ld_valid = 1'b0;
  endtask

  task automatic rd(input int a);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    tick();
    rd_en   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_restart = 1'b0;
    swap_req = 1'b0; rd_en = 1'b0; rd_addr = '0;
    tick(); tick();
    check("rst_ld_ready", RW'(ld_ready), RW'(0));
    check("rst_bank_sel", RW'(bank_sel), RW'(0));
    check("rst_act_valid", RW'(act_valid), RW'(0));
    check("rst_ld_done", RW'(ld_done), RW'(0));
    check("rst_rd_valid", RW'(rd_valid), RW'(0));
    check("rst_rd_data", rd_data, '0);
    rst_n = 1'b1;
    tick();
    check("ld_ready_after_rst", RW'(ld_ready), RW'(1));

    // 1: full load, swap, read addr 5
    load(0, 0, NB);
    check("t1_ld_done", RW'(ld_done), RW'(1));
    check("t1_ld_ready_full", RW'(ld_ready), RW'(0));
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("t1_bank_sel", RW'(bank_sel), RW'(1));
    check("t1_act_valid", RW'(act_valid), RW'(1));
    check("t1_ld_done_clr", RW'(ld_done), RW'(0));
    rd(5);
    check("t1_rd_valid", RW'(rd_valid), RW'(1));
    check("t1_rd_data", rd_data, row(0, 5));

    // 3: swap during half-load ignored; active bank unaltered
    load(3, 0, NB / 2);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("t3_bank_sel", RW'(bank_sel), RW'(1));
    check("t3_ld_done", RW'(ld_done), RW'(0));
    rd(5);
    check("t3_rd_data", rd_data, row(0, 5));
    load(3, NB / 2, NB - NB / 2);
    check("t3_ld_done_full", RW'(ld_done), RW'(1));

    // 2: backpressure while FULL
    ld_valid = 1'b1; ld_data = 16'hDEAD;
    for (int i = 0; i < 10; i++) tick();
    ld_valid = 1'b0;
    check("t2_ld_ready", RW'(ld_ready), RW'(0));
    check("t2_ld_done", RW'(ld_done), RW'(1));

    // 4: read coincident with swap returns old bank
    rd_en = 1'b1; rd_addr = '0; swap_req = 1'b1;
    tick();
    rd_en = 1'b0; swap_req = 1'b0;
    check("t4_rd_old_bank", rd_data, row(0, 0));
    check("t4_bank_sel", RW'(bank_sel), RW'(0));
    rd(0);
    check("t4_rd_new_bank", rd_data, row(3, 0));
    rd(DEPTH - 1);
    check("t4_rd_last_addr", rd_data, row(3, DEPTH - 1));
    tick();
    check("t4_rd_valid_idle", RW'(rd_valid), RW'(0));
    check("t4_rd_data_hold", rd_data, row(3, DEPTH - 1));
    rd(DEPTH);
    check("t4_rd_oob_data", rd_data, '0);
    check("t4_rd_oob_valid", RW'(rd_valid), RW'(1));

    // 5: restart after 7 beats (beat with restart dropped), reload 0xAAAA
    load(3, 0, 7);
    ld_valid = 1'b1; ld_data = 16'h5555; ld_restart = 1'b1;
    tick();
    ld_valid = 1'b0; ld_restart = 1'b0;
    check("t5_act_valid_kept", RW'(act_valid), RW'(1));
    load(1, 0, NB);
    check("t5_ld_done", RW'(ld_done), RW'(1));
    ld_restart = 1'b1; swap_req = 1'b1;
    tick();
    ld_restart = 1'b0; swap_req = 1'b0;
    check("t5_restart_wins_bank", RW'(bank_sel), RW'(0));
    check("t5_restart_wins_done", RW'(ld_done), RW'(0));
    check("t5_restart_ready", RW'(ld_ready), RW'(1));
    load(1, 0, NB);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("t5_bank_sel", RW'(bank_sel), RW'(1));
    for (int a = 0; a < DEPTH; a++) begin
      rd(a);
      check($sformatf("t5_rd_aaaa_%0d", a), rd_data, row(1, a));
    end

    // 6: reset mid-load, then full load of ones
    load(2, 0, 100);
    rst_n = 1'b0;
    #1;
    check("t6_ld_ready_in_rst", RW'(ld_ready), RW'(0));
    tick();
    rst_n = 1'b1;
    check("t6_act_valid_rst", RW'(act_valid), RW'(0));
    check("t6_bank_sel_rst", RW'(bank_sel), RW'(0));
    check("t6_rd_data_rst", rd_data, '0);
    load(2, 0, NB);
    check("t6_act_valid_pre_swap", RW'(act_valid), RW'(0));
    check("t6_ld_done", RW'(ld_done), RW'(1));
`ifdef KERNEL_COEFF_CKSUM_EN
    check("t6_cksum", RW'(cksum), RW'(NB));
`endif
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("t6_act_valid", RW'(act_valid), RW'(1));
    check("t6_bank_sel", RW'(bank_sel), RW'(1));
    rd(DEPTH - 1);
    check("t6_rd_ones", rd_data, row(2, DEPTH - 1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
